// File: rtl/modulator_pkg.sv
// Shared constants for the sine-PWM modulator: default geometry and nominal clock/tone rates.
package modulator_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 12;
    localparam int DIV_W_DEF = 32;

    localparam int CLK_NOMINAL_HZ  = 100_000_000;
    localparam int FREQ_LOW_HZ     = 10;
    localparam int FREQ_HIGH_HZ    = 35;

    // Clocks per sine sample giving roughly the nominal tones at 100 MHz.
    localparam int DIV_LOW_NOMINAL  = 40960;
    localparam int DIV_HIGH_NOMINAL = 12288;

endpackage

// File: rtl/sine_rom.sv
// Full-period sine lookup table, offset to unsigned full scale; combinational read.
module sine_rom
    import modulator_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [DEPTH-1:0] idx,
    output logic [WIDTH-1:0] sample
);

    localparam int  N         = 2 ** DEPTH;
    localparam real PI        = 3.14159265358979323846;
    localparam real HALF_SPAN = real'((2 ** WIDTH) - 1) / 2.0;

    // Evaluated only at elaboration; the argument is always non-negative so $rtoi floors.
    function automatic int sine_entry(input int i);
        return $rtoi(HALF_SPAN * (1.0 + $sin(2.0 * PI * real'(i) / real'(N))));
    endfunction

    logic [WIDTH-1:0] rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam int ENTRY = sine_entry(g);
        assign rom[g] = ENTRY[WIDTH-1:0];
    end

    assign sample = rom[idx];

endmodule

// File: rtl/modulator.sv
// Sine-weighted PWM generator with two selectable sample rates.
// Define MODULATOR_SYNC_SW_EN to pass sw0 through a two-flop synchronizer before selection.
module modulator
    import modulator_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sw0,
    input  logic [DIV_W-1:0] div_factor_freqhigh,
    input  logic [DIV_W-1:0] div_factor_freqlow,
    output logic             pwm
);

    logic sw_sel;

`ifdef MODULATOR_SYNC_SW_EN
    logic sw_meta;
    logic sw_sync;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sw_meta <= 1'b0;
            sw_sync <= 1'b0;
        end else begin
            sw_meta <= sw0;
            sw_sync <= sw_meta;
        end
    end

    assign sw_sel = sw_sync;
`else
    assign sw_sel = sw0;
`endif

    logic [DIV_W-1:0] sel_div;
    logic [DIV_W-1:0] next_div;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] sample_timer;
    logic [DEPTH-1:0] sample_idx;
    logic             sample_end;

    assign sel_div    = sw_sel ? div_factor_freqhigh : div_factor_freqlow;
    assign next_div   = (sel_div == '0) ? DIV_W'(1) : sel_div;
    assign sample_end = (sample_timer == active_div - DIV_W'(1));

    // The divide factor is only re-latched at a sample boundary, so a rate change never trims a sample.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            active_div   <= next_div;
            sample_timer <= '0;
            sample_idx   <= '0;
        end else if (sample_end) begin
            active_div   <= next_div;
            sample_timer <= '0;
            sample_idx   <= sample_idx + DEPTH'(1);
        end else begin
            sample_timer <= sample_timer + DIV_W'(1);
        end
    end

    logic [WIDTH-1:0] carrier_cnt;
    logic             carrier_end;
    logic [WIDTH-1:0] rom_sample;

    assign carrier_end = (carrier_cnt == '1);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            carrier_cnt <= '0;
        end else begin
            carrier_cnt <= carrier_cnt + WIDTH'(1);
        end
    end

    sine_rom #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_sine_rom (
        .idx    (sample_idx),
        .sample (rom_sample)
    );

    logic [WIDTH-1:0] duty_p0;
    logic             pwm_p1;

    // Stage 0: duty captured on the last carrier clock so it is stable for a whole carrier period.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            duty_p0 <= '0;
        end else if (carrier_end) begin
            duty_p0 <= rom_sample;
        end
    end

    // Stage 1: registered comparator output.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pwm_p1 <= 1'b0;
        end else begin
            pwm_p1 <= (carrier_cnt < duty_p0);
        end
    end

    assign pwm = pwm_p1;

endmodule

// File: tb/tb_modulator.sv
// Directed self-checking bench for the sine-PWM modulator.
module tb_modulator;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        sw0    = 1'b1;
    logic [31:0] div_high = 32'd12288;
    logic [31:0] div_low  = 32'd12288;
    logic        pwm;

    int total = 0;
    int bad   = 0;

`ifdef MODULATOR_SYNC_SW_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    modulator dut (
        .clk_in              (clk_in),
        .rst                 (rst),
        .sw0                 (sw0),
        .div_factor_freqhigh (div_high),
        .div_factor_freqlow  (div_low),
        .pwm                 (pwm)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int highs;
        sw0 = 1'b1; div_high = 32'd12288; div_low = 32'd12288;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm cyc%0d: got %b want 0", k, pwm); end
            total++;
            if (dut.sample_idx !== 8'd0) begin bad++; $display("FAIL reset_idx cyc%0d: got %0d want 0", k, dut.sample_idx); end
        end
        rst = 1'b0;
        highs = 0;
        for (int e = 1; e <= 4096; e++) begin step(); highs += int'(pwm); end
        total++;
        if (highs != 0) begin bad++; $display("FAIL first_period_high: got %0d want 0", highs); end
        highs = 0;
        for (int e = 4097; e <= 8192; e++) begin step(); highs += int'(pwm); end
        total++;
        if (highs != 2047) begin bad++; $display("FAIL idx0_period_high: got %0d want 2047", highs); end
        repeat (12287 - 8192) step();
        total++;
        if (dut.sample_idx !== 8'd0) begin bad++; $display("FAIL idx_before_12288: got %0d want 0", dut.sample_idx); end
        step();
        total++;
        if (dut.sample_idx !== 8'd1) begin bad++; $display("FAIL idx_at_12288: got %0d want 1", dut.sample_idx); end
    endtask

    task automatic test_div_zero();
        sw0 = 1'b1; div_high = 32'd0; div_low = 32'd0;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (dut.sample_idx !== k[7:0]) begin bad++; $display("FAIL div0_idx edge%0d: got %0d want %0d", k, dut.sample_idx, k); end
        end
    endtask

    // Step the index one per clock, freeze it at target by switching to a long divide, then measure one carrier period.
    task automatic test_sine_point(input int target, input int exp_high);
        int e;
        int highs;
        sw0 = 1'b1; div_high = 32'd0; div_low = 32'd0;
        do_reset();
        e = 0;
        while (e < target - 1 - LAT) begin step(); e++; end
        sw0 = 1'b0; div_low = 32'd40960;
        while (e < target + 1) begin step(); e++; end
        total++;
        if (dut.sample_idx !== target[7:0]) begin bad++; $display("FAIL freeze_idx t%0d: got %0d want %0d", target, dut.sample_idx, target); end
        while (e < 4096) begin step(); e++; end
        highs = 0;
        while (e < 8192) begin step(); e++; highs += int'(pwm); end
        total++;
        if (highs != exp_high) begin bad++; $display("FAIL sine_high t%0d: got %0d want %0d", target, highs, exp_high); end
        total++;
        if (dut.sample_idx !== target[7:0]) begin bad++; $display("FAIL hold_idx t%0d: got %0d want %0d", target, dut.sample_idx, target); end
    endtask

    task automatic test_mid_reset();
        repeat (100) step();
        total++;
        if (pwm !== 1'b1) begin bad++; $display("FAIL pre_reset_pwm: got %b want 1", pwm); end
        rst = 1'b1;
        step();
        total++;
        if (pwm !== 1'b0) begin bad++; $display("FAIL mid_reset_pwm: got %b want 0", pwm); end
        total++;
        if (dut.sample_idx !== 8'd0) begin bad++; $display("FAIL mid_reset_idx: got %0d want 0", dut.sample_idx); end
        total++;
        if (dut.carrier_cnt !== 12'd0) begin bad++; $display("FAIL mid_reset_carrier: got %0d want 0", dut.carrier_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_switch_mid_sample();
        int e;
        sw0 = 1'b1; div_high = 32'd12288; div_low = 32'd12288;
        do_reset();
        div_low = 32'd40960;
        e = 0;
        while (e < 5000) begin step(); e++; end
        sw0 = 1'b0;
        while (e < 12287) begin step(); e++; end
        total++;
        if (dut.sample_idx !== 8'd0) begin bad++; $display("FAIL sw_idx_before_12288: got %0d want 0", dut.sample_idx); end
        step(); e++;
        total++;
        if (dut.sample_idx !== 8'd1) begin bad++; $display("FAIL sw_idx_at_12288: got %0d want 1", dut.sample_idx); end
        while (e < 53247) begin step(); e++; end
        total++;
        if (dut.sample_idx !== 8'd1) begin bad++; $display("FAIL sw_idx_before_53248: got %0d want 1", dut.sample_idx); end
        step(); e++;
        total++;
        if (dut.sample_idx !== 8'd2) begin bad++; $display("FAIL sw_idx_at_53248: got %0d want 2", dut.sample_idx); end
    endtask

    initial begin
        test_reset();
        test_div_zero();
        test_sine_point(64, 4095);
        test_mid_reset();
        test_sine_point(192, 0);
        test_switch_mid_sample();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modulator.md
MODULATOR -- requirements
Module: modulator

Interface
REQ-001 Parameter DEPTH, default 8: log2 of sine samples per output period (256 samples).
REQ-002 Parameter WIDTH, default 12: amplitude bits per sample; PWM carrier period is 2^WIDTH clocks.
REQ-003 Parameter DIV_W, default 32: width of the divide-factor inputs.
REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sw0  input  1  frequency select: 1 selects div_factor_freqhigh, 0 selects div_factor_freqlow.
REQ-007 div_factor_freqhigh  input  DIV_W  clocks per sine sample for the high frequency (12288 for 35 Hz nominal at 100 MHz).
REQ-008 div_factor_freqlow  input  DIV_W  clocks per sine sample for the low frequency (40960 for 10 Hz nominal at 100 MHz).
REQ-009 pwm  output  1  registered PWM output whose duty cycle follows the sine samples.

Function
REQ-010 Sine ROM: entry i = floor((2^WIDTH-1)/2 * (1 + sin(2*pi*i/2^DEPTH))); defaults give entry 0 = 2047, entry 64 = 4095, entry 192 = 0.
REQ-011 Carrier counter: free-running, WIDTH bits, counts 0..2^WIDTH-1, wraps to 0.
REQ-012 Sample timer: counts 0..active_div-1; on its terminal count the sample index (DEPTH bits) increments modulo 2^DEPTH and the timer returns to 0.
REQ-013 active_div is latched from the sw0-selected input only at a sample boundary (terminal count) and at reset release; a sw0 or divide-factor change mid-sample never shortens or extends the current sample.
REQ-014 A selected divide factor of 0 is treated as 1 (index advances every clock).
REQ-015 Duty register: loads ROM[sample index] only on the cycle the carrier counter equals 2^WIDTH-1, so duty never changes inside a carrier period.
REQ-016 pwm register: next value = (carrier counter < duty); duty 0 gives constant low; duty 2^WIDTH-1 gives exactly one low clock per carrier period.
REQ-017 Output period is 2^DEPTH * active_div clocks; the sample timer and the carrier counter are independent.

Reset
REQ-018 While rst is high: carrier counter, sample timer, sample index, duty and pwm are 0; active_div is loaded from the sw0-selected input.
REQ-019 After rst falls, the first carrier period outputs pwm low for all 4096 clocks; the second carrier period carries ROM[current index].
REQ-020 rst asserted mid-operation takes effect on the next clock edge and discards any partial sample or carrier period.

Configuration
REQ-021 Macro MODULATOR_SYNC_SW_EN defined: sw0 passes through a two-flop synchronizer (reset to 0) before selection, adding 2 clocks of latency; undefined: sw0 is used directly.

Structure
REQ-022 Shared package modulator_pkg holds DEPTH/WIDTH defaults and the 100 MHz nominal clock and 10 Hz / 35 Hz nominal frequency constants.
REQ-023 Sine table is a single sub-module sine_rom (index in, WIDTH-bit sample out, combinational or one-clock registered read, with duty load timing adjusted to match REQ-015).

Verification
REQ-024 Reset: rst high for 3 clocks with sw0=1 -> pwm=0 and index=0 throughout; pwm stays 0 for the 4096 clocks after release.
REQ-025 sw0=1, high=12288: index increments every 12288 clocks; full sine period = 3,145,728 clocks.
REQ-026 sw0=0, low=40960: index increments every 40960 clocks; at index 0 a carrier period shows 2047 high clocks, at index 64 4095, at index 192 0.
REQ-027 Toggle sw0 1->0 at 5000 clocks into a sample: current sample still lasts 12288 clocks; the next sample lasts 40960.
REQ-028 Divide factor 0: index advances every clock; with MODULATOR_SYNC_SW_EN, selection changes are 2 clocks later than without it.
